// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one pipe_skid_reg stage.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface pipe_skid_reg_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output count
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  count
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready and a synchronous flush.
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | word in main, can still accept one more
//   ST_FULL  | main and skid both held, in_ready=0
module pipe_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_flush,
   pipe_skid_reg_if.slave  s_bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_ready  = (r_state != ST_FULL);
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = s_bus.in_valid & w_in_ready;
   assign w_out_fire  = w_out_valid & s_bus.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt = ST_ONE;
               w_main_nxt  = s_bus.in_data;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_nxt = s_bus.in_data;
            end else if (w_in_fire) begin
               w_state_nxt = ST_FULL;
               w_skid_nxt  = s_bus.in_data;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_state_nxt = ST_ONE;
               w_main_nxt  = r_skid;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush drops everything held; the data registers are left as-is since nothing reads them when empty.
      if (i_flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = r_main;
         w_skid_nxt  = r_skid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   assign s_bus.in_ready  = w_in_ready;
   assign s_bus.out_valid = w_out_valid;
   assign s_bus.out_data  = r_main;
   assign s_bus.count     = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed handshake scenarios followed by a long random run.
`timescale 1ns/1ps
module tb_pipe_skid_reg;
   localparam int WIDTH = 8;

   logic i_clk = 1'b0;
   logic i_reset;
   logic i_flush;

   pipe_skid_reg_if #(.WIDTH(WIDTH)) u_if ();

   pipe_skid_reg #(.WIDTH(WIDTH)) u_dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_flush),
      .s_bus   (u_if.slave)
   );

   always #5 i_clk = ~i_clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [WIDTH-1:0] sb_q[$];
   bit               exp_zero;
   bit               hold_prev;
   logic [WIDTH-1:0] data_prev;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int n;
      n = sb_q.size();
      check_val("count", 32'(u_if.count), 32'(n));
      check_val("in_ready", 32'(u_if.in_ready), 32'(n != 2));
      check_val("out_valid", 32'(u_if.out_valid), 32'(n != 0));
      if (n != 0) check_val("order", 32'(u_if.out_data), 32'(sb_q[0]));
      if (exp_zero) check_val("rst_data", 32'(u_if.out_data), 32'd0);
      if (hold_prev) check_val("stable", 32'(u_if.out_data), 32'(data_prev));
   endtask

   // Called at negedge: check state from the last edge, then drive and advance the model.
   task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit f, input bit rst);
      int  n;
      bit  in_fire;
      bit  out_fire;
      check_outputs();
      u_if.in_valid  = v;
      u_if.in_data   = d;
      u_if.out_ready = r;
      i_flush        = f;
      i_reset        = rst;
      n         = sb_q.size();
      in_fire   = v && (n != 2);
      out_fire  = r && (n != 0);
      hold_prev = (n != 0) && !r && !f && !rst;
      data_prev = u_if.out_data;
      exp_zero  = rst;
      if (rst || f) begin
         sb_q.delete();
      end else begin
         if (out_fire) void'(sb_q.pop_front());
         if (in_fire) sb_q.push_back(d);
      end
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   initial begin
      u_if.in_valid  = 1'b0;
      u_if.in_data   = '0;
      u_if.out_ready = 1'b0;
      i_flush        = 1'b0;
      i_reset        = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset  = 1'b0;
      exp_zero = 1'b1;

      // reset mid-stream while full
      cycle(1, 8'h3C, 0, 0, 0);
      cycle(1, 8'h3D, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0);

      // back-to-back streaming, count stays at 1
      cycle(1, 8'h11, 1, 0, 0);
      cycle(1, 8'h22, 1, 0, 0);
      cycle(1, 8'h33, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);

      // stall to full, offered word ignored, then drain and resend
      cycle(1, 8'hA1, 0, 0, 0);
      cycle(1, 8'hA2, 0, 0, 0);
      cycle(1, 8'hA3, 0, 0, 0);
      cycle(1, 8'hA3, 0, 0, 0);
      cycle(1, 8'hA3, 1, 0, 0);
      cycle(1, 8'hA3, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);

      // simultaneous in/out fire at count 1
      cycle(1, 8'h4B, 0, 0, 0);
      cycle(1, 8'h5C, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);

      // flush while full with a coincident upstream word
      cycle(1, 8'h61, 0, 0, 0);
      cycle(1, 8'h62, 0, 0, 0);
      cycle(1, 8'h77, 0, 1, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);

      // random traffic with occasional flush and reset
      for (int i = 0; i < 10000; i++) begin
         cycle(bit'($urandom_range(0, 1)),
               WIDTH'($urandom_range(0, 255)),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 511) == 0));
      end
      cycle(0, 8'h00, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
